// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Definitions shared by the RV32I data-memory controller and its datapath
// helper: load/store funct3 encodings, controller state encoding, response
// error codes, and the legality/alignment check applied when a request is
// accepted.
// ---------------------------------------------------------------------------
package rv32i_pkg;

  // Load/store size encodings (funct3). Stores only use B/H/W.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } dmem_state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } dmem_err_e;

  // An unknown funct3 has no defined access size, so it is reported as
  // illegal before alignment is considered.
  function automatic dmem_err_e check_access(input logic       we,
                                             input logic [2:0] funct3,
                                             input logic [1:0] addr_lsb);
    logic legal;
    if (we) legal = funct3 inside {F3_B, F3_H, F3_W};
    else    legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};

    if (!legal)
      return ERR_ILLEGAL;
    if ((funct3 == F3_H || funct3 == F3_HU) && addr_lsb[0])
      return ERR_MISALIGN;
    if (funct3 == F3_W && addr_lsb != 2'b00)
      return ERR_MISALIGN;
    return ERR_OK;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// ---------------------------------------------------------------------------
// dmem_align
// Purely combinational lane logic for 32-bit RV32I data accesses.
//   Store side: byte enables and lane-replicated write data from
//               funct3 / addr_lsb / wdata.
//   Load side : selects the addressed byte or halfword of a memory word and
//               sign- or zero-extends it according to funct3.
// Ports:
//   we         in   1 = store (loads always enable all four lanes)
//   funct3     in   access size / signedness
//   addr_lsb   in   byte offset within the word
//   wdata      in   unaligned store data (rs2)
//   be         out  byte enables
//   wdata_rep  out  store data replicated across the lanes
//   rdata_word in   word returned by memory
//   rdata_ext  out  extracted and extended load data
// ---------------------------------------------------------------------------
module dmem_align
  import rv32i_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lsb,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [31:0] rdata_word,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every signal written in an always_comb block gets a default first,
  // so no path through the case statements can leave it unassigned and
  // infer a latch.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    if (we) begin
      case (funct3)
        F3_B: begin
          be        = 4'b0001 << addr_lsb;
          wdata_rep = {4{wdata[7:0]}};
        end
        F3_H: begin
          be        = addr_lsb[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_sel = rdata_word[7:0];
    case (addr_lsb)
      2'd1:    byte_sel = rdata_word[15:8];
      2'd2:    byte_sel = rdata_word[23:16];
      2'd3:    byte_sel = rdata_word[31:24];
      default: ;
    endcase
    half_sel = addr_lsb[1] ? rdata_word[31:16] : rdata_word[15:0];

    rdata_ext = rdata_word;
    case (funct3)
      F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_ext = {24'd0, byte_sel};
      F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_ext = {16'd0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
// Sequences one RV32I load/store at a time between the MEM stage and a
// single-port request/grant/rvalid data memory. Checks legality and
// alignment at accept, issues the access with byte enables and replicated
// store data, stalls the pipeline while it runs, and returns extended load
// data or an error code (misaligned, timeout, illegal funct3).
// Every output is decoded from registered state; mem_* inputs never reach
// mem_* outputs combinationally.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         core request handshake (ready only in IDLE)
//   req_we/req_funct3/req_addr/req_wdata  request fields
//   rsp_valid/rsp_rdata/rsp_err one-cycle response
//   busy                        pipeline stall, high outside IDLE
//   mem_req/mem_gnt             memory request handshake
//   mem_addr/mem_we/mem_be/mem_wdata      memory command (valid in ISSUE)
//   mem_rvalid/mem_rdata        read data / write acknowledge
// DATA_WIDTH must be 32.
// ---------------------------------------------------------------------------
module dmem_ctrl
  import rv32i_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  busy,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter reads 0 in the first WAIT cycle, so the last permitted WAIT
  // cycle is the one in which it reads TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  dmem_state_e           state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            lsb_q;
  logic [ADDR_WIDTH-1:2] word_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  dmem_err_e             err_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  accept;
  dmem_err_e             acc_err;
  logic                  timeout_hit;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] rdata_ext;

  assign accept      = req_valid && (state_q == IDLE);
  assign acc_err     = check_access(req_we, req_funct3, req_addr[1:0]);
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  dmem_align u_align (
    .we         (we_q),
    .funct3     (funct3_q),
    .addr_lsb   (lsb_q),
    .wdata      (wdata_q),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_word (mem_rdata),
    .rdata_ext  (rdata_ext)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (acc_err == ERR_OK) ? ISSUE : RESP;
      ISSUE:   if (mem_gnt) state_d = WAIT;
      WAIT:    if (mem_rvalid || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the capture registers are reset as well as the state, because
  // the response outputs are driven from them and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      lsb_q       <= 2'b00;
      word_addr_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
    end else begin
      if (accept) begin
        we_q        <= req_we;
        funct3_q    <= req_funct3;
        lsb_q       <= req_addr[1:0];
        word_addr_q <= req_addr[ADDR_WIDTH-1:2];
        wdata_q     <= req_wdata;
        rdata_q     <= '0;
        err_q       <= acc_err;
      end
      if (state_q == WAIT) begin
        // rvalid wins over a coincident timeout.
        if (mem_rvalid) begin
          err_q   <= ERR_OK;
          rdata_q <= we_q ? '0 : rdata_ext;
        end else if (timeout_hit) begin
          err_q   <= ERR_TIMEOUT;
          rdata_q <= '0;
        end
      end
    end
  end

  // Runs only while waiting for rvalid; cleared in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cnt_q <= '0;
    else if (TIMEOUT_EN && state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
    else                                    cnt_q <= '0;
  end

  // The memory command is gated to ISSUE so the bus reads 0 elsewhere and
  // holds the captured values, unchanged, until the grant.
  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = ERR_OK;
    case (state_q)
      ISSUE: begin
        mem_req   = 1'b1;
        mem_addr  = {word_addr_q, 2'b00};
        mem_we    = we_q;
        mem_be    = be;
        mem_wdata = wdata_rep;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Sequences every RV32I data-memory transaction between the MEM stage and a single-port, handshake-based data memory. It accepts one load/store request at a time, generates byte enables and lane-replicated store data, and holds the pipeline while the transfer runs. It then returns sign/zero-extended load data, or an error code for misaligned, illegal or timed-out accesses.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_CYCLES, 255, maximum WAIT cycles before timeout; 0 disables the timeout. Counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  unaligned store data (rs2)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
busy  out  1  stall to pipeline; high whenever state != IDLE
mem_req  out  1  memory request
mem_gnt  in  1  memory accepts request
mem_addr  out  ADDR_WIDTH  word address, low 2 bits forced to 0
mem_we  out  1  write strobe
mem_be  out  4  byte enables
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_rvalid  in  1  read data valid / write acknowledge
mem_rdata  in  DATA_WIDTH  read data word

Behaviour:
- Reset, asynchronous: state = IDLE. All outputs are 0 except req_ready = 1. Timeout counter = 0. Reset mid-transaction abandons it silently; no rsp_valid is produced.
- All outputs are registered or decoded from registered state only. There is no combinational path from mem_* inputs to mem_* outputs.
- Accept: the request is captured when req_valid && req_ready. The captured fields are we, funct3, addr[1:0], word address and wdata.
- Legality check at accept:
  - Load funct3 in {000,001,010,100,101} is legal.
  - Store funct3 in {000,001,010} is legal.
  - Anything else gives err 11.
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0, gives err 01.
- States and transitions:
  - IDLE -> ISSUE on accept of a legal, aligned request.
  - IDLE -> RESP on accept with an error; no memory access is made.
  - ISSUE: mem_req = 1 with addr/we/be/wdata held stable until mem_gnt. mem_req is never retracted. The timeout counter is not running. ISSUE -> WAIT on mem_gnt.
  - WAIT: the counter increments each cycle.
    - WAIT -> RESP on mem_rvalid, with err 00. Load data is extracted from mem_rdata using the captured funct3 and addr[1:0].
    - WAIT -> RESP when the counter reaches TIMEOUT_CYCLES (nonzero) without mem_rvalid, with err 10 and rsp_rdata = 0.
    - mem_rvalid in the same cycle as the timeout wins: err 00.
  - RESP: rsp_valid = 1 for exactly one cycle, then -> IDLE. The counter is cleared.
- mem_rvalid outside WAIT (stray or late after timeout) is ignored. mem_rvalid cannot arrive in the same cycle as mem_gnt; it is sampled only in WAIT.
- Byte enables:
  - sb: 0001 << addr[1:0].
  - sh: 0011 at addr[1] = 0, 1100 at addr[1] = 1.
  - sw: 1111.
  - Loads: mem_be = 1111 and mem_we = 0.
- Store data: sb replicates wdata[7:0] into all four bytes; sh replicates wdata[15:0] into both halves; sw passes wdata unchanged.
- Load extraction: lb/lh sign-extend and lbu/lhu zero-extend the selected byte or halfword; lw passes the word unchanged.
- Minimum latency, accept to rsp_valid:
  - Legal access with mem_gnt in the first ISSUE cycle and mem_rvalid in the first WAIT cycle: 3 cycles (accept in cycle 0, rsp_valid in cycle 3).
  - Error response: 1 cycle.
- Back-to-back: a new request can be accepted in the cycle after RESP.

Decomposition:
- Shared package rv32i_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - dmem state encoding: IDLE, ISSUE, WAIT, RESP.
  - rsp_err codes: ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL.
- One combinational sub-module, dmem_align, is natural. It generates byte enables and store replication from funct3/addr_lsb, and extracts and extends load data from a word. dmem_ctrl holds the FSM, capture registers and timeout counter.

Test Plan:
- sb, addr 0x1003, wdata 0xAB; memory grants immediately and acks 1 cycle later -> mem_addr 0x1000, mem_be 1000, mem_wdata 0xABABABAB, mem_we 1; rsp_valid in cycle 3 with err 00.
- lb at addr 0x2002; mem_rdata 0x1280FF00 -> rsp_rdata 0xFFFFFF80. lbu at the same address -> 0x00000080. lh at 0x2002 -> 0x00001280.
- lw at 0x3001 -> no mem_req; rsp_valid the cycle after accept with err 01. A store with funct3 101 -> err 11. busy is high for exactly one cycle in both cases.
- mem_gnt held low for 5 cycles -> mem_req and all mem_* outputs stay stable for those 5 cycles; the response is delayed accordingly.
- TIMEOUT_CYCLES = 4, no mem_rvalid -> err 10, rsp_rdata 0. A stray mem_rvalid 2 cycles later, in IDLE, is ignored. The next lw completes normally.
- rst_n pulsed low while in WAIT -> outputs reset immediately and no rsp_valid is produced. After release, a new sw is accepted with req_ready = 1.
